// File: rtl/sched_event_logger_pkg.sv
// rtl/sched_event_logger_pkg.sv - shared field layout and stage equation for the event logger
package sched_event_logger_pkg;

    localparam int IDX_A  = 3;
    localparam int IDX_B  = 2;
    localparam int IDX_C  = 1;
    localparam int IDX_D  = 0;
    localparam int MASK_W = 4;
    localparam int VAL_W  = 4;

    // Record layout, LSB first: {ts, mask, val}
    localparam int VAL_LSB  = 0;
    localparam int MASK_LSB = VAL_LSB + VAL_W;
    localparam int TS_LSB   = MASK_LSB + MASK_W;

    function automatic int rec_w(input int ts_w);
        return ts_w + MASK_W + VAL_W;
    endfunction

    // Scheduling stage contract: c = a & b, d = a | (b ^ c)
    function automatic logic rule_ok(input logic [MASK_W-1:0] v);
        logic exp_c;
        logic exp_d;
        exp_c = v[IDX_A] & v[IDX_B];
        exp_d = v[IDX_A] | (v[IDX_B] ^ v[IDX_C]);
        return (v[IDX_C] == exp_c) && (v[IDX_D] == exp_d);
    endfunction

endpackage

// File: rtl/sched_evt_fifo.sv
// rtl/sched_evt_fifo.sv - synchronous valid/ready FIFO with level output
module sched_evt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_tdata,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    output logic [WIDTH-1:0]         out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign out_tvalid = (level != '0);
    // A full FIFO still accepts when the head leaves on the same edge
    assign in_tready  = (level != FULL_LVL) || out_tready;
    assign push       = in_tvalid && in_tready;
    assign pop        = out_tvalid && out_tready;
    assign out_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_tdata;
    end

endmodule

// File: rtl/sched_event_logger.sv
// rtl/sched_event_logger.sv - samples the scheduling stage, queues change events, checks the equations
module sched_event_logger
    import sched_event_logger_pkg::*;
#(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a,
    input  logic                       b,
    input  logic                       c,
    input  logic                       d,
    input  logic                       clr,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [TS_W+7:0]            evt_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           evt_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       overflow,
    output logic                       rule_err
);

    localparam int REC_W = rec_w(TS_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MASK_W-1:0] cur;
    logic [MASK_W-1:0] s_q;
    logic [MASK_W-1:0] mask;
    logic              primed;
    logic [TS_W-1:0]   ts;
    logic [REC_W-1:0]  rec;
    logic              evt;
    logic              push_rdy;
    logic              pushed;
    logic              dropped;
    logic              viol;

    always_comb begin
        cur        = '0;
        cur[IDX_A] = a;
        cur[IDX_B] = b;
        cur[IDX_C] = c;
        cur[IDX_D] = d;
    end

    assign mask = cur ^ s_q;
    // The first edge after reset only loads s_q, so nothing is detected or checked there
    assign evt  = primed && (mask != '0);
    assign viol = primed && !rule_ok(cur);

    always_comb begin
        rec = '0;
        rec[TS_LSB   +: TS_W]   = ts;
        rec[MASK_LSB +: MASK_W] = mask;
        rec[VAL_LSB  +: VAL_W]  = cur;
    end

    sched_evt_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_tdata   (rec),
        .in_tvalid  (evt),
        .in_tready  (push_rdy),
        .out_tdata  (evt_data),
        .out_tvalid (evt_valid),
        .out_tready (evt_ready),
        .level      (fifo_level)
    );

    assign pushed  = evt && push_rdy;
    assign dropped = evt && !push_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= '0;
            primed     <= 1'b0;
            ts         <= '0;
            evt_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            rule_err   <= 1'b0;
        end else begin
            s_q    <= cur;
            primed <= 1'b1;
            ts     <= ts + 1'b1;

            // clr zeroes first, then this edge's own activity is applied on top
            if (clr)
                evt_count <= pushed ? CNT_W'(1) : '0;
            else if (pushed && evt_count != CNT_MAX)
                evt_count <= evt_count + 1'b1;

            if (clr)
                drop_count <= dropped ? CNT_W'(1) : '0;
            else if (dropped && drop_count != CNT_MAX)
                drop_count <= drop_count + 1'b1;

            overflow <= (overflow && !clr) || dropped;
            rule_err <= (rule_err && !clr) || viol;
        end
    end

endmodule

// File: tb/tb_sched_event_logger.sv
// tb/tb_sched_event_logger.sv - directed self-checking bench for sched_event_logger
module tb_sched_event_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        a, b, c, d;
    logic        clr;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_data;
    logic [2:0]  fifo_level;
    logic [7:0]  evt_count;
    logic [7:0]  drop_count;
    logic        overflow;
    logic        rule_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sched_event_logger #(
        .TS_W  (8),
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .clr        (clr),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .fifo_level (fifo_level),
        .evt_count  (evt_count),
        .drop_count (drop_count),
        .overflow   (overflow),
        .rule_err   (rule_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    function automatic logic [15:0] mk_rec(input logic [7:0] t, input logic [3:0] m, input logic [3:0] v);
        return {t, m, v};
    endfunction

    logic [7:0] exp_ts [4];

    initial begin
        rst = 1'b1; clr = 1'b0; evt_ready = 1'b0;
        set_in(4'b0000);
        tick();
        check("rst_valid",    32'(evt_valid),  0);
        check("rst_level",    32'(fifo_level), 0);
        check("rst_count",    32'(evt_count),  0);
        check("rst_drop",     32'(drop_count), 0);
        check("rst_overflow", 32'(overflow),   0);
        check("rst_rule_err", 32'(rule_err),   0);
        rst = 1'b0;

        // 1: quiet inputs produce nothing
        repeat (10) tick();
        check("t1_valid",    32'(evt_valid),  0);
        check("t1_count",    32'(evt_count),  0);
        check("t1_rule_err", 32'(rule_err),   0);
        check("t1_level",    32'(fifo_level), 0);

        // 2: fresh reset so the change lands on the ts=5 edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        set_in(4'b1001);
        evt_ready = 1'b1;
        tick();
        check("t2_valid", 32'(evt_valid), 1);
        check("t2_data",  32'(evt_data),  32'h0599);
        check("t2_count", 32'(evt_count), 1);
        tick();
        check("t2_popped", 32'(evt_valid), 0);

        // 3: overflow with consumer stalled (clr on ts=7, changes on ts=8..13)
        evt_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_clr_count", 32'(evt_count), 0);
        for (int i = 0; i < 6; i++) begin
            set_in((i % 2 == 0) ? 4'b0000 : 4'b1001);
            tick();
        end
        check("t3_level",    32'(fifo_level), 4);
        check("t3_count",    32'(evt_count),  4);
        check("t3_drop",     32'(drop_count), 2);
        check("t3_overflow", 32'(overflow),   1);
        evt_ready = 1'b1;
        exp_ts = '{8'd8, 8'd9, 8'd10, 8'd11};
        for (int i = 0; i < 4; i++) begin
            check("t3_drain_valid", 32'(evt_valid), 1);
            check("t3_drain_data",  32'(evt_data),
                  32'(mk_rec(exp_ts[i], 4'b1001, (i % 2 == 0) ? 4'b0000 : 4'b1001)));
            tick();
        end
        check("t3_empty",       32'(evt_valid), 0);
        check("t3_overflow_st", 32'(overflow),  1);

        // 4: full FIFO with pop and push on the same edge (fill on ts=18..21, swap on ts=22)
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in((i % 2 == 0) ? 4'b0000 : 4'b1001);
            tick();
        end
        check("t4_full", 32'(fifo_level), 4);
        evt_ready = 1'b1;
        set_in(4'b0000);
        tick();
        check("t4_level_held", 32'(fifo_level), 4);
        check("t4_drop_held",  32'(drop_count), 2);
        check("t4_count",      32'(evt_count),  9);
        exp_ts = '{8'd19, 8'd20, 8'd21, 8'd22};
        for (int i = 0; i < 4; i++) begin
            check("t4_drain_data", 32'(evt_data),
                  32'(mk_rec(exp_ts[i], 4'b1001, (i % 2 == 0) ? 4'b1001 : 4'b0000)));
            tick();
        end
        check("t4_empty", 32'(evt_valid), 0);

        // ts wrap: idle through ts=27..254, change on 255 and again on 0
        repeat (228) tick();
        set_in(4'b1001);
        tick();
        check("t4_ts255", 32'(evt_data), 32'(mk_rec(8'd255, 4'b1001, 4'b1001)));
        set_in(4'b0000);
        tick();
        check("t4_ts0",       32'(evt_data),   32'(mk_rec(8'd0, 4'b1001, 4'b0000)));
        check("t4_ts0_level", 32'(fifo_level), 1);

        // 5: rule checker
        set_in(4'b1101);
        tick();
        check("t5_err_set", 32'(rule_err), 1);
        set_in(4'b1111);
        tick();
        check("t5_err_sticky", 32'(rule_err), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_err_clr",  32'(rule_err),   0);
        check("t5_ovf_clr",  32'(overflow),   0);
        check("t5_drop_clr", 32'(drop_count), 0);
        check("t5_cnt_clr",  32'(evt_count),  0);
        set_in(4'b0000);
        tick();
        check("t5_err_clean", 32'(rule_err), 0);
        // d-only violation: a=0,b=1,c=0 demands d=1
        set_in(4'b0100);
        tick();
        check("t5_err_d", 32'(rule_err), 1);
        clr = 1'b1;
        set_in(4'b0000);
        tick();
        clr = 1'b0;
        check("t5_clr_evt_count", 32'(evt_count), 1);
        check("t5_clr_evt_err",   32'(rule_err),  0);
        tick();

        // 6: reset with records queued
        check("t6_drained", 32'(fifo_level), 0);
        evt_ready = 1'b0;
        set_in(4'b1001); tick();
        set_in(4'b0000); tick();
        set_in(4'b1001); tick();
        check("t6_level3", 32'(fifo_level), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(evt_valid),  0);
        check("t6_level", 32'(fifo_level), 0);
        check("t6_count", 32'(evt_count),  0);
        check("t6_drop",  32'(drop_count), 0);
        set_in(4'b0000);
        tick();
        check("t6_unprimed_valid", 32'(evt_valid), 0);
        check("t6_unprimed_count", 32'(evt_count), 0);
        set_in(4'b1001);
        tick();
        check("t6_primed_valid", 32'(evt_valid), 1);
        check("t6_primed_count", 32'(evt_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
